shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq_pkg.sv | 45 ++++
 rtl/shift_seq_step.sv | 26 ++
 rtl/shift_seq.sv | 114 +++++++++++
 tb/tb_shift_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings and helpers for the shift_seq sequential shifter.
// SHIFT_SEQ_ROTATE_EN enables ROR/ROL; otherwise those ops behave as PASS.
package shift_seq_pkg;

    localparam int AMT_W = 5;
    localparam logic [AMT_W-1:0] CONST_SIXTEEN = 5'd16;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_SLL  = 3'b001,
        OP_SRL  = 3'b010,
        OP_SRA  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        SRC_OFFSET = 2'b00,
        SRC_CONST  = 2'b01,
        SRC_REGB   = 2'b10,
        SRC_ZERO   = 2'b11
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Ops that do not move data run with a zero count so they finish immediately.
    function automatic logic op_uses_count(input logic [2:0] op);
        logic uses;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: uses = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR, OP_ROL:         uses = 1'b1;
`endif
            default:                uses = 1'b0;
        endcase
        return uses;
    endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Combinational one-bit shift/rotate step used by shift_seq.
// Rotate cases exist only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_seq_step
    import shift_seq_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  op,
    output logic [31:0] data_next
);

    // Single-bit step selected by the latched operation
    always_comb begin
        data_next = data;
        case (op)
            OP_SLL:  data_next = {data[30:0], 1'b0};
            OP_SRL:  data_next = {1'b0, data[31:1]};
            OP_SRA:  data_next = {data[31], data[31:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR:  data_next = {data[0], data[31:1]};
            OP_ROL:  data_next = {data[30:0], data[31]};
`endif
            default: data_next = data;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: IDLE -> SHIFT (one bit per cycle) -> DONE pulse.
// Optional rotate support via SHIFT_SEQ_ROTATE_EN.
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [1:0]  src_sel,
    input  logic [15:0] offset,
    input  logic [31:0] reg_a,
    input  logic [31:0] reg_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  shamt_left
);

    state_e            state_r;
    state_e            state_s;
    logic [31:0]       data_r;
    logic [AMT_W-1:0]  cnt_r;
    op_e               op_r;
    logic              busy_r;
    logic              done_r;
    logic [AMT_W-1:0]  amount_s;
    logic [AMT_W-1:0]  load_cnt_s;
    logic [31:0]       step_s;
    logic              unused_s;

    assign unused_s = ^{offset[15:11], offset[5:0], reg_b[31:5]};

    // Amount source selection
    always_comb begin
        amount_s = 5'd0;
        case (src_sel)
            SRC_OFFSET: amount_s = offset[10:6];
            SRC_CONST:  amount_s = CONST_SIXTEEN;
            SRC_REGB:   amount_s = reg_b[4:0];
            SRC_ZERO:   amount_s = 5'd0;
            default:    amount_s = 5'd0;
        endcase
    end

    assign load_cnt_s = op_uses_count(op) ? amount_s : 5'd0;

    shift_seq_step u_step (
        .data      (data_r),
        .op        (op_r),
        .data_next (step_s)
    );

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == 5'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            data_r  <= 32'd0;
            cnt_r   <= 5'd0;
            op_r    <= OP_PASS;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_SHIFT);
            done_r  <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        data_r <= reg_a;
                        cnt_r  <= load_cnt_s;
                        op_r   <= op_e'(op);
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r != 5'd0) begin
                        data_r <= step_s;
                        cnt_r  <= cnt_r - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = data_r;
    assign shamt_left = cnt_r;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_shift_seq;

`ifdef SHIFT_SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  src_sel = 2'd0;
    logic [15:0] offset = 16'd0;
    logic [31:0] reg_a = 32'd0;
    logic [31:0] reg_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  shamt_left;

    int checks = 0;
    int passes = 0;

    shift_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_sel    (src_sel),
        .offset     (offset),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .shamt_left (shamt_left)
    );

    always #5 clk = ~clk;

    function automatic int ref_amount(input logic [2:0] o, input logic [1:0] s,
                                      input logic [15:0] off, input logic [31:0] b);
        int n;
        case (s)
            2'b00:   n = int'(off[10:6]);
            2'b01:   n = 16;
            2'b10:   n = int'(b[4:0]);
            default: n = 0;
        endcase
        if (o == 3'b001 || o == 3'b010 || o == 3'b011) return n;
        if ((o == 3'b100 || o == 3'b101) && ROT_EN) return n;
        return 0;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input int n);
        logic [63:0] dbl;
        dbl = {a, a};
        case (o)
            3'b001: return a << n;
            3'b010: return a >> n;
            3'b011: return 32'($signed(a) >>> n);
            3'b100: begin dbl = dbl >> n; return dbl[31:0]; end
            3'b101: begin dbl = dbl << n; return dbl[63:32]; end
            default: return a;
        endcase
    endfunction

    // Launch one operation and observe 40 cycles; k counts cycles after start.
    task automatic do_shift(input logic [2:0] o, input logic [1:0] s, input logic [15:0] off,
                            input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                            output logic [31:0] res, output int done_cyc, output int done_cnt,
                            output int busy_cnt, output int busy_first, output logic [4:0] shamt1);
        @(negedge clk);
        start = 1'b1; op = o; src_sel = s; offset = off; reg_a = a; reg_b = b;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1; shamt1 = 5'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) shamt1 = shamt_left;
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (pulse_at != 0 && k == pulse_at) begin
                start = 1'b1; reg_a = ~a; op = 3'b001;
            end else begin
                start = 1'b0;
            end
        end
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 3'b001; reg_a = 32'hDEADBEEF; src_sel = 2'b01;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, shamt_left} !== {1'b0, 1'b0, 32'd0, 5'd0})
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h shamt=%0d, want 0/0/0/0",
                     busy, done, result, shamt_left);
        else passes++;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result !== 32'd0)
            $display("FAIL reset_idle: got busy=%b result=%h, want 0/0", busy, result);
        else passes++;
    endtask

    task automatic test_directed(input string name, input logic [2:0] o, input logic [1:0] s,
                                 input logic [15:0] off, input logic [31:0] a, input logic [31:0] b,
                                 input int pulse_at, input logic [31:0] exp_res, input int exp_n);
        logic [31:0] res;
        int dc, dn, bc, bf;
        logic [4:0] sh1;
        do_shift(o, s, off, a, b, pulse_at, res, dc, dn, bc, bf, sh1);
        checks++;
        if (res !== exp_res) $display("FAIL %s_result: got %h, want %h", name, res, exp_res);
        else passes++;
        checks++;
        if (dc !== exp_n + 2 || dn !== 1)
            $display("FAIL %s_done: got cycle t+%0d count %0d, want t+%0d count 1", name, dc, dn, exp_n + 2);
        else passes++;
        checks++;
        if (bf !== 1 || bc !== exp_n + 1)
            $display("FAIL %s_busy: got first t+%0d cycles %0d, want first t+1 cycles %0d", name, bf, bc, exp_n + 1);
        else passes++;
        checks++;
        if (sh1 !== 5'(exp_n)) $display("FAIL %s_shamt: got %0d, want %0d", name, sh1, exp_n);
        else passes++;
    endtask

    task automatic test_mid_reset();
        int dn;
        @(negedge clk);
        start = 1'b1; op = 3'b001; src_sel = 2'b00; offset = 16'(10 << 6); reg_a = 32'h0000_0003;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) reset = 1'b1;
        end
        checks++;
        if ({busy, done, result, shamt_left} !== {1'b0, 1'b0, 32'd0, 5'd0})
            $display("FAIL midreset_outputs: got busy=%b done=%b result=%h shamt=%0d, want 0/0/0/0",
                     busy, done, result, shamt_left);
        else passes++;
        reset = 1'b0;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn !== 0) $display("FAIL midreset_nodone: got %0d done pulses, want 0", dn);
        else passes++;
        test_directed("midreset_fresh", 3'b001, 2'b00, 16'(10 << 6), 32'h0000_0003, 32'd0, 0,
                      32'h0000_0C00, 10);
    endtask

    task automatic test_rotate();
        test_directed("rotate", 3'b100, 2'b10, 16'd0, 32'h0000_0001, 32'h0000_0001, 0,
                      ROT_EN ? 32'h8000_0000 : 32'h0000_0001, ROT_EN ? 1 : 0);
    endtask

    task automatic test_random();
        logic [31:0] res, a, b;
        logic [15:0] off;
        logic [2:0] o;
        logic [1:0] s;
        logic [4:0] sh1;
        int dc, dn, bc, bf, n;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            s = 2'($urandom_range(0, 3));
            off = 16'($urandom);
            a = $urandom;
            b = $urandom;
            n = ref_amount(o, s, off, b);
            do_shift(o, s, off, a, b, 0, res, dc, dn, bc, bf, sh1);
            checks++;
            if (res !== ref_result(o, a, n))
                $display("FAIL rand%0d_result: op=%b n=%0d got %h, want %h", i, o, n, res, ref_result(o, a, n));
            else passes++;
            checks++;
            if (dc !== n + 2 || bc !== n + 1)
                $display("FAIL rand%0d_timing: got done t+%0d busy %0d, want done t+%0d busy %0d",
                         i, dc, bc, n + 2, n + 1);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_directed("sll", 3'b001, 2'b00, 16'(4 << 6), 32'h0000_0001, 32'd0, 0, 32'h0000_0010, 4);
        test_directed("sra", 3'b011, 2'b10, 16'd0, 32'h8000_0000, 32'hFFFF_FFE3, 0, 32'hF000_0000, 3);
        test_directed("srl", 3'b010, 2'b01, 16'd0, 32'hABCD_1234, 32'd0, 3, 32'h0000_ABCD, 16);
        test_directed("zero", 3'b001, 2'b11, 16'hFFFF, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 0);
        test_directed("pass", 3'b000, 2'b01, 16'd0, 32'hCAFE_F00D, 32'd0, 0, 32'hCAFE_F00D, 0);
        test_directed("rsvd", 3'b111, 2'b10, 16'd0, 32'h0F0F_0F0F, 32'h0000_0007, 0, 32'h0F0F_0F0F, 0);
        test_directed("sll31", 3'b001, 2'b10, 16'd0, 32'h0000_0001, 32'hFFFF_FFFF, 0, 32'h8000_0000, 31);
        test_mid_reset();
        test_rotate();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
